mcp_src_ctrl: RTL and testbench
===============================

Name: mcp_src_ctrl

Overview:
- Source-side controller for a multi-cycle-path (MCP) transfer.
- Accepts one data word on a valid/ready interface and holds it stable on a bus toggle request `mcp_req`, using a level-toggle protocol.
- The destination domain returns a toggle acknowledge, `mcp_ack`. This block brings it into its own clock through an internal SYNC_STAGES-deep flop synchronizer, then frees the bus.
- Sits between a source-domain producer and the crossing data bus; the paired destination-side sync/capture logic lives elsewhere.

Parameters:
- DW, 32: width of the transferred data word.
- SYNC_STAGES, 2: flops in the ack synchronizer chain; legal range 2..4.
- CNT_W, 16: width of the completed-transfer counter.
- TIMEOUT_CYC, 1024: cycles spent in WAIT_ACK before a timeout. Used only with MCP_TIMEOUT_EN.

Ports:
- clk  input  1  single clock (source domain).
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word.
- in_data  input  DW  word to transfer.
- mcp_data  output  DW  registered data bus to destination; stable while a transfer is outstanding.
- mcp_req  output  1  request toggle; flips once per transfer.
- mcp_ack  input  1  ack toggle from destination; asynchronous to clk.
- done  output  1  one-cycle pulse when a transfer completes.
- busy  output  1  high while a transfer is outstanding.
- xfer_cnt  output  CNT_W  number of completed transfers; wraps.
- err  output  1  sticky timeout flag; exists only with MCP_TIMEOUT_EN.
- err_clr  input  1  clears err and returns to IDLE; exists only with MCP_TIMEOUT_EN.

Behaviour:
- Reset (async assert, released on clk): state=IDLE, mcp_data=0, mcp_req=0, all sync flops=0, done=0, xfer_cnt=0, err=0. Outputs: in_ready=1, busy=0.
- ack_s is the last stage of the SYNC_STAGES chain clocked by clk from mcp_ack. No logic sits between stages.
- FSM states: IDLE, WAIT_ACK, plus ERR with the macro.
- IDLE:
  - in_ready=1, busy=0.
  - On in_valid&in_ready at edge N: mcp_data<=in_data, mcp_req<=~mcp_req, state<=WAIT_ACK.
- WAIT_ACK:
  - in_ready=0, busy=1; mcp_data and mcp_req are held.
  - When ack_s==mcp_req at an edge: state<=IDLE, done<=1 for exactly one cycle, xfer_cnt<=xfer_cnt+1 (wraps 2^CNT_W-1 -> 0).
- done and in_ready are high in the same cycle. A word presented then is accepted, giving back-to-back transfers with no idle gap.
- Minimum round-trip with an immediately echoing ack (mcp_ack follows mcp_req combinationally): SYNC_STAGES+1 cycles from the accept edge to the edge that returns to IDLE.
- ack_s changes while in IDLE (ack_s!=mcp_req) are a protocol violation. They are ignored: no done, no counter change. The next transfer then waits for ack_s to match the new mcp_req.
- in_data is sampled only at the accept edge. Changes to in_valid/in_data while busy have no effect.
- Reset mid-transfer returns everything to reset values immediately and aborts the transfer with no done. Destination-side logic must be reset together with this block.

Optional Feature:
- Macro: MCP_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle.
  - When it reaches TIMEOUT_CYC-1 without a match: state<=ERR, err<=1 (sticky), no done.
  - ERR: in_ready=0, busy=1; mcp_req and mcp_data are held.
  - err_clr=1 at an edge: err<=0, state<=IDLE, mcp_req<=ack_s (realigned). This takes priority over everything else in ERR.
  - An ack match on the same edge as expiry wins: completes normally.
- Undefined: err and err_clr ports are absent, there is no counter, and WAIT_ACK waits indefinitely.

Test Plan:
- Reset release, then in_valid=1 with in_data=0xA5A5_0001 and mcp_ack looped to mcp_req. Required: mcp_req 0->1 at accept; done pulse 3 cycles later (SYNC_STAGES=2); xfer_cnt=1; mcp_data=0xA5A5_0001 throughout.
- Four words 0x1..0x4 back-to-back with looped ack. Required: each accepted in its done cycle; mcp_req toggles 4 times; xfer_cnt=4; no idle gap.
- Ack delayed 20 cycles, with in_data changing every cycle while busy. Required: mcp_data stays at the accepted value; in_ready=0 for the full wait; single done.
- mcp_ack toggled while IDLE. Required: no done; xfer_cnt unchanged; next transfer completes only on the following matching ack.
- rst asserted mid-WAIT_ACK. Required: mcp_req=0, busy=0, in_ready=1, xfer_cnt=0 immediately; no done.
- MCP_TIMEOUT_EN with TIMEOUT_CYC=16 and ack never returned. Required: err=1 after 16 WAIT_ACK cycles; in_ready=0 until err_clr; after err_clr, mcp_req equals ack_s and a new transfer completes.

Source files
------------

// File: rtl/mcp_src_ctrl.sv
// Source-side controller for a toggle-handshake multi-cycle-path transfer.
// Optional ack timeout with sticky error is enabled by defining MCP_TIMEOUT_EN.
module mcp_src_ctrl #(
  parameter int unsigned DW          = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic [DW-1:0]    mcp_data,
  output logic             mcp_req,
  input  logic             mcp_ack,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt
`ifdef MCP_TIMEOUT_EN
  ,
  output logic             err,
  input  logic             err_clr
`endif
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("mcp_src_ctrl: SYNC_STAGES must be 2..4 and TIMEOUT_CYC at least 2");
  end

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
`ifdef MCP_TIMEOUT_EN
  localparam logic [1:0] ERR      = 2'd2;
  localparam int unsigned TW      = $clog2(TIMEOUT_CYC);
`endif

  logic [1:0]             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic [DW-1:0]          data_d;
  logic                   req_d;
  logic                   done_d;
  logic [CNT_W-1:0]       cnt_d;
`ifdef MCP_TIMEOUT_EN
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   err_d;
`endif

  assign ack_s    = sync_q[SYNC_STAGES-1];
  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    data_d  = mcp_data;
    req_d   = mcp_req;
    done_d  = 1'b0;
    cnt_d   = xfer_cnt;
`ifdef MCP_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err;
`endif
    case (state_q)
      IDLE: begin
        // Stray ack toggles here are deliberately ignored.
        if (in_valid) begin
          data_d  = in_data;
          req_d   = ~mcp_req;
          state_d = WAIT_ACK;
`ifdef MCP_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      WAIT_ACK: begin
        if (ack_s == mcp_req) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = xfer_cnt + 1'b1;
        end
`ifdef MCP_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
`ifdef MCP_TIMEOUT_EN
      ERR: begin
        // Realign the request to the synchronized ack so the next transfer starts clean.
        if (err_clr) begin
          err_d   = 1'b0;
          state_d = IDLE;
          req_d   = ack_s;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      mcp_data <= '0;
      mcp_req  <= 1'b0;
      done     <= 1'b0;
      xfer_cnt <= '0;
`ifdef MCP_TIMEOUT_EN
      tmo_q    <= '0;
      err      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], mcp_ack};
      mcp_data <= data_d;
      mcp_req  <= req_d;
      done     <= done_d;
      xfer_cnt <= cnt_d;
`ifdef MCP_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err      <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mcp_src_ctrl.sv
// Directed bench for mcp_src_ctrl: per-cycle vector table plus hand-written corner sequences.
module tb_mcp_src_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] mcp_data;
  logic        mcp_req;
  logic        mcp_ack;
  logic        done;
  logic        busy;
  logic [15:0] xfer_cnt;
  logic        loop_ack;
  logic        ack_man;
`ifdef MCP_TIMEOUT_EN
  logic        err;
  logic        err_clr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mcp_ack = loop_ack ? mcp_req : ack_man;

  mcp_src_ctrl #(
    .DW         (32),
    .SYNC_STAGES(2),
    .CNT_W      (16),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .mcp_data(mcp_data),
    .mcp_req (mcp_req),
    .mcp_ack (mcp_ack),
    .done    (done),
    .busy    (busy),
    .xfer_cnt(xfer_cnt)
`ifdef MCP_TIMEOUT_EN
    ,
    .err     (err),
    .err_clr (err_clr)
`endif
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        rdy;
    logic        bsy;
    logic        dn;
    logic        req;
    logic [15:0] cnt;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic v, logic [31:0] d, logic rdy, logic bsy, logic dn,
                              logic req, logic [15:0] cnt, logic [31:0] data);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.bsy = bsy; r.dn = dn;
    r.req = req; r.cnt = cnt; r.data = data;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps up to max edges looking for a done pulse; returns the edge count at which it was seen.
  task automatic wait_done(input int max, output int seen_at);
    seen_at = -1;
    for (int k = 1; k <= max; k++) begin
      tick();
      if (done === 1'b1) begin
        seen_at = k;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int at;
  int ndone;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    loop_ack = 1'b1;
    ack_man  = 1'b0;
`ifdef MCP_TIMEOUT_EN
    err_clr  = 1'b0;
`endif

    //          v   d             rdy bsy dn req cnt data
    tbl[0]  = mk(1, 32'hA5A5_0001, 0, 1, 0, 1, 0, 32'hA5A5_0001);
    tbl[1]  = mk(0, 32'h0,         0, 1, 0, 1, 0, 32'hA5A5_0001);
    tbl[2]  = mk(0, 32'h0,         0, 1, 0, 1, 0, 32'hA5A5_0001);
    tbl[3]  = mk(0, 32'h0,         1, 0, 1, 1, 1, 32'hA5A5_0001);
    tbl[4]  = mk(0, 32'h0,         1, 0, 0, 1, 1, 32'hA5A5_0001);
    tbl[5]  = mk(1, 32'h1,         0, 1, 0, 0, 1, 32'h1);
    tbl[6]  = mk(1, 32'h2,         0, 1, 0, 0, 1, 32'h1);
    tbl[7]  = mk(1, 32'h2,         0, 1, 0, 0, 1, 32'h1);
    tbl[8]  = mk(1, 32'h2,         1, 0, 1, 0, 2, 32'h1);
    tbl[9]  = mk(1, 32'h2,         0, 1, 0, 1, 2, 32'h2);
    tbl[10] = mk(1, 32'h3,         0, 1, 0, 1, 2, 32'h2);
    tbl[11] = mk(1, 32'h3,         0, 1, 0, 1, 2, 32'h2);
    tbl[12] = mk(1, 32'h3,         1, 0, 1, 1, 3, 32'h2);
    tbl[13] = mk(1, 32'h3,         0, 1, 0, 0, 3, 32'h3);
    tbl[14] = mk(1, 32'h4,         0, 1, 0, 0, 3, 32'h3);
    tbl[15] = mk(1, 32'h4,         0, 1, 0, 0, 3, 32'h3);
    tbl[16] = mk(1, 32'h4,         1, 0, 1, 0, 4, 32'h3);
    tbl[17] = mk(1, 32'h4,         0, 1, 0, 1, 4, 32'h4);
    tbl[18] = mk(0, 32'h0,         0, 1, 0, 1, 4, 32'h4);
    tbl[19] = mk(0, 32'h0,         0, 1, 0, 1, 4, 32'h4);
    tbl[20] = mk(0, 32'h0,         1, 0, 1, 1, 5, 32'h4);
    tbl[21] = mk(0, 32'h0,         1, 0, 0, 1, 5, 32'h4);

    do_reset();
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_req", {31'b0, mcp_req}, 32'd0);
    chk("rst_cnt", {16'b0, xfer_cnt}, 32'd0);
    chk("rst_data", mcp_data, 32'd0);

    // Looped ack: single transfer then four back-to-back words.
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      tick();
      chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].rdy});
      chk($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].bsy});
      chk($sformatf("vec%0d_done", i), {31'b0, done}, {31'b0, tbl[i].dn});
      chk($sformatf("vec%0d_req", i), {31'b0, mcp_req}, {31'b0, tbl[i].req});
      chk($sformatf("vec%0d_cnt", i), {16'b0, xfer_cnt}, {16'b0, tbl[i].cnt});
      chk($sformatf("vec%0d_data", i), mcp_data, tbl[i].data);
    end

    // Ack held off 20 cycles while in_data churns; request now goes 1 -> 0.
    @(negedge clk);
    ack_man  = 1'b1;
    loop_ack = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_0001;
    tick();
    chk("dly_req", {31'b0, mcp_req}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_data = 32'hC0DE_0000 + i;
      tick();
      chk("dly_data_hold", mcp_data, 32'hDEAD_0001);
      chk("dly_in_ready", {31'b0, in_ready}, 32'd0);
      if (done === 1'b1) ndone++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    ack_man  = 1'b0;
    wait_done(10, at);
    if (at > 0) ndone++;
    chk("dly_done_edge", at, 32'd3);
    tick();
    chk("dly_done_count", ndone, 32'd1);
    chk("dly_cnt", {16'b0, xfer_cnt}, 32'd6);

    // Stray ack toggles in IDLE must be ignored.
    @(negedge clk);
    ack_man = 1'b1;
    repeat (4) @(negedge clk);
    ack_man = 1'b0;
    wait_done(5, at);
    chk("stray_no_done", at, 32'hFFFF_FFFF);
    chk("stray_cnt", {16'b0, xfer_cnt}, 32'd6);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h0000_BEEF;
    tick();
    in_valid = 1'b0;
    chk("stray_req", {31'b0, mcp_req}, 32'd1);
    wait_done(8, at);
    chk("stray_wait_no_done", at, 32'hFFFF_FFFF);
    @(negedge clk);
    ack_man = 1'b1;
    wait_done(5, at);
    chk("stray_done_edge", at, 32'd3);
    chk("stray_cnt_after", {16'b0, xfer_cnt}, 32'd7);

    // Reset in the middle of WAIT_ACK.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    chk("mid_busy_pre", {31'b0, busy}, 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_req", {31'b0, mcp_req}, 32'd0);
    chk("mid_busy", {31'b0, busy}, 32'd0);
    chk("mid_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_cnt", {16'b0, xfer_cnt}, 32'd0);
    chk("mid_done", {31'b0, done}, 32'd0);
    ack_man = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_done(4, at);
    chk("mid_no_done", at, 32'hFFFF_FFFF);

`ifdef MCP_TIMEOUT_EN
    // Ack never returns: error after 16 WAIT_ACK cycles, then recover with err_clr.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h7777_0001;
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    chk("tmo_err_pre", {31'b0, err}, 32'd0);
    tick();
    chk("tmo_err", {31'b0, err}, 32'd1);
    chk("tmo_done", {31'b0, done}, 32'd0);
    repeat (5) tick();
    chk("tmo_in_ready", {31'b0, in_ready}, 32'd0);
    chk("tmo_err_sticky", {31'b0, err}, 32'd1);
    chk("tmo_data_hold", mcp_data, 32'h7777_0001);
    @(negedge clk);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_err_clr", {31'b0, err}, 32'd0);
    chk("tmo_req_realign", {31'b0, mcp_req}, 32'd0);
    chk("tmo_ready_after", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    loop_ack = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h7777_0002;
    tick();
    in_valid = 1'b0;
    wait_done(6, at);
    chk("tmo_recover_done", at, 32'd3);
    chk("tmo_recover_cnt", {16'b0, xfer_cnt}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
